// File: rtl/env_window_pkg.sv
// env_window_pkg: shared sizes, neighbour indices and cell/column types for
// the 3x3 environment window builder.
package env_window_pkg;

  localparam int GRID_W      = 160;
  localparam int GRID_H      = 120;
  localparam int X_bits      = 8;
  localparam int Y_bits      = 7;
  localparam int SIGNAL_bits = 4;

  localparam int DIR_N  = 0;
  localparam int DIR_NE = 1;
  localparam int DIR_E  = 2;
  localparam int DIR_SE = 3;
  localparam int DIR_S  = 4;
  localparam int DIR_SW = 5;
  localparam int DIR_W  = 6;
  localparam int DIR_NW = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_PADROW = 2'd2
  } state_t;

  // One grid cell as carried through the line buffers.
  typedef struct packed {
    logic                   sugar;
    logic [SIGNAL_bits-1:0] signal;
  } cell_t;

  // One window column: [0] = row vy-2, [1] = row vy-1, [2] = row vy.
  typedef cell_t [2:0] col_t;

  // Returns the signal of a cell, or 0 when the neighbour lies off the grid.
  function automatic logic [SIGNAL_bits-1:0] masked_signal(input cell_t c, input logic keep);
    return keep ? c.signal : '0;
  endfunction

endpackage

// File: rtl/env_window_line_buffer.sv
// line_buffer: one grid row of cells, combinational read of the old value and
// write of the new value at the same address on the same clock.
module line_buffer
  import env_window_pkg::*;
#(
  parameter int DEPTH = GRID_W + 1,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  cell_t         wdata,
  output cell_t         rdata
);

  cell_t mem_q [DEPTH];

  assign rdata = mem_q[addr];

  // Store the incoming cell; the read above still sees the previous row's value.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

endmodule

// File: rtl/env_window.sv
// env_window: turns the raster stream of {sugar, signal} cells into one 3x3
// neighbourhood per grid cell, one row and one column behind the input.
// A padded raster (one extra column and row of zero cells) flushes the last
// row/column through the window.
module env_window #(
  parameter int GRID_W = env_window_pkg::GRID_W,
  parameter int GRID_H = env_window_pkg::GRID_H
) (
  input  logic                                          clk,
  input  logic                                          RESET_SIM_N,
  input  logic                                          run,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [env_window_pkg::X_bits-1:0]             in_x,
  input  logic [env_window_pkg::Y_bits-1:0]             in_y,
  input  logic [env_window_pkg::SIGNAL_bits-1:0]        in_signal,
  input  logic                                          in_sugar,
  output logic                                          out_valid,
  output logic [env_window_pkg::X_bits-1:0]             out_x,
  output logic [env_window_pkg::Y_bits-1:0]             out_y,
  output logic [env_window_pkg::SIGNAL_bits-1:0]        cur_signal,
  output logic                                          cur_sugar,
  output logic [7:0][env_window_pkg::SIGNAL_bits-1:0]   surrounding_signals,
  output logic                                          frame_done,
  output logic                                          err_sync
);
  import env_window_pkg::*;

  localparam int                LB_AW  = $clog2(GRID_W + 1);
  localparam logic [X_bits-1:0] X_PAD  = X_bits'(GRID_W);
  localparam logic [Y_bits-1:0] Y_PAD  = Y_bits'(GRID_H);
  localparam logic [Y_bits-1:0] Y_LAST = Y_bits'(GRID_H - 1);
  localparam logic [X_bits-1:0] X_ONE  = X_bits'(1);
  localparam logic [Y_bits-1:0] Y_ONE  = Y_bits'(1);
  localparam logic [X_bits-1:0] X_TWO  = X_bits'(2);
  localparam logic [Y_bits-1:0] Y_TWO  = Y_bits'(2);

  state_t                       state_q, state_d;
  logic [X_bits-1:0]            vx_q, vx_d;
  logic [Y_bits-1:0]            vy_q, vy_d;
  col_t                         col_c_q, col_c_d;
  col_t                         col_w_q, col_w_d;
  logic                         out_valid_q, out_valid_d;
  logic [X_bits-1:0]            out_x_q, out_x_d;
  logic [Y_bits-1:0]            out_y_q, out_y_d;
  logic [SIGNAL_bits-1:0]       cur_signal_q, cur_signal_d;
  logic                         cur_sugar_q, cur_sugar_d;
  logic [7:0][SIGNAL_bits-1:0]  surr_q, surr_d;
  logic                         frame_done_q, frame_done_d;
  logic                         err_sync_q, err_sync_d;

  logic  ready_c;
  logic  step;
  logic  drop_err;
  logic  scan_abort;
  logic  in_grid;
  logic  pos_match;
  logic  at_origin;
  logic  west_ok, east_ok, north_ok, south_ok;
  cell_t in_cell;
  cell_t new_cell;
  cell_t lb1_rd;
  cell_t lb2_rd;
  col_t  col_e;

  assign in_cell   = {in_sugar, in_signal};
  assign in_grid   = (vx_q < X_PAD) && (vy_q < Y_PAD);
  assign pos_match = (in_x == vx_q) && (in_y == vy_q);
  assign at_origin = (in_x == '0) && (in_y == '0);

  // The freshly stepped column: two buffered rows above the new cell.
  assign col_e = {new_cell, lb1_rd, lb2_rd};

  // Neighbours off the grid are decided purely from the cursor, never from buffer contents.
  assign west_ok  = (vx_q >= X_TWO);
  assign east_ok  = (vx_q != X_PAD);
  assign north_ok = (vy_q >= Y_TWO);
  assign south_ok = (vy_q != Y_PAD);

  // Decide whether this cycle advances the cursor, and with which cell.
  always_comb begin
    ready_c    = 1'b0;
    step       = 1'b0;
    new_cell   = '0;
    drop_err   = 1'b0;
    scan_abort = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        ready_c = run;
        if (run && in_valid) begin
          if (at_origin) begin
            step     = 1'b1;
            new_cell = in_cell;
          end else begin
            drop_err = 1'b1;
          end
        end
      end
      ST_SCAN: begin
        if (in_grid) begin
          ready_c = run;
          if (run && in_valid) begin
            if (pos_match) begin
              step     = 1'b1;
              new_cell = in_cell;
            end else begin
              drop_err   = 1'b1;
              scan_abort = 1'b1;
            end
          end
        end else begin
          step = run;
        end
      end
      ST_PADROW: begin
        step = run;
      end
      default: begin
        step = 1'b0;
      end
    endcase
  end

  // Next cursor, window shift, registered window outputs and status flags.
  always_comb begin
    state_d      = state_q;
    vx_d         = vx_q;
    vy_d         = vy_q;
    col_c_d      = col_c_q;
    col_w_d      = col_w_q;
    out_valid_d  = 1'b0;
    out_x_d      = out_x_q;
    out_y_d      = out_y_q;
    cur_signal_d = cur_signal_q;
    cur_sugar_d  = cur_sugar_q;
    surr_d       = surr_q;
    frame_done_d = 1'b0;
    err_sync_d   = err_sync_q | drop_err;

    if (scan_abort) begin
      state_d = ST_IDLE;
      vx_d    = '0;
      vy_d    = '0;
    end

    if (step) begin
      col_w_d = col_c_q;
      col_c_d = col_e;
      if (state_q == ST_IDLE) begin
        state_d = ST_SCAN;
      end
      if (vx_q == X_PAD) begin
        vx_d = '0;
        if (vy_q == Y_PAD) begin
          vy_d         = '0;
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
        end else begin
          vy_d = vy_q + Y_ONE;
          if (vy_q == Y_LAST) begin
            state_d = ST_PADROW;
          end
        end
      end else begin
        vx_d = vx_q + X_ONE;
      end

      if ((vx_q != '0) && (vy_q != '0)) begin
        out_valid_d    = 1'b1;
        out_x_d        = vx_q - X_ONE;
        out_y_d        = vy_q - Y_ONE;
        cur_signal_d   = col_c_q[1].signal;
        cur_sugar_d    = col_c_q[1].sugar;
        surr_d[DIR_N]  = masked_signal(col_c_q[0], north_ok);
        surr_d[DIR_NE] = masked_signal(col_e[0],   north_ok && east_ok);
        surr_d[DIR_E]  = masked_signal(col_e[1],   east_ok);
        surr_d[DIR_SE] = masked_signal(col_e[2],   south_ok && east_ok);
        surr_d[DIR_S]  = masked_signal(col_c_q[2], south_ok);
        surr_d[DIR_SW] = masked_signal(col_w_q[2], south_ok && west_ok);
        surr_d[DIR_W]  = masked_signal(col_w_q[1], west_ok);
        surr_d[DIR_NW] = masked_signal(col_w_q[0], north_ok && west_ok);
      end
    end
  end

  // Scan FSM, window columns and output registers with asynchronous abort.
  always_ff @(posedge clk or negedge RESET_SIM_N) begin
    if (!RESET_SIM_N) begin
      state_q      <= ST_IDLE;
      vx_q         <= '0;
      vy_q         <= '0;
      col_c_q      <= '0;
      col_w_q      <= '0;
      out_valid_q  <= 1'b0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      cur_signal_q <= '0;
      cur_sugar_q  <= 1'b0;
      surr_q       <= '0;
      frame_done_q <= 1'b0;
      err_sync_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      vx_q         <= vx_d;
      vy_q         <= vy_d;
      col_c_q      <= col_c_d;
      col_w_q      <= col_w_d;
      out_valid_q  <= out_valid_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
      cur_signal_q <= cur_signal_d;
      cur_sugar_q  <= cur_sugar_d;
      surr_q       <= surr_d;
      frame_done_q <= frame_done_d;
      err_sync_q   <= err_sync_d;
    end
  end

  line_buffer #(.DEPTH(GRID_W + 1), .AW(LB_AW)) u_lb_row1 (
    .clk   (clk),
    .we    (step),
    .addr  (vx_q[LB_AW-1:0]),
    .wdata (new_cell),
    .rdata (lb1_rd)
  );

  line_buffer #(.DEPTH(GRID_W + 1), .AW(LB_AW)) u_lb_row2 (
    .clk   (clk),
    .we    (step),
    .addr  (vx_q[LB_AW-1:0]),
    .wdata (lb1_rd),
    .rdata (lb2_rd)
  );

  assign in_ready            = ready_c & RESET_SIM_N;
  assign out_valid           = out_valid_q;
  assign out_x               = out_x_q;
  assign out_y               = out_y_q;
  assign cur_signal          = cur_signal_q;
  assign cur_sugar           = cur_sugar_q;
  assign surrounding_signals = surr_q;
  assign frame_done          = frame_done_q;
  assign err_sync            = err_sync_q;

endmodule

// File: tb/tb_env_window.sv
// tb_env_window: drives 4x3 frames into env_window and compares every window
// against neighbourhoods computed directly from the frame contents.
module tb_env_window;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int XB = env_window_pkg::X_bits;
  localparam int YB = env_window_pkg::Y_bits;
  localparam int SB = env_window_pkg::SIGNAL_bits;

  logic                 clk;
  logic                 RESET_SIM_N;
  logic                 run;
  logic                 in_valid;
  logic                 in_ready;
  logic [XB-1:0]        in_x;
  logic [YB-1:0]        in_y;
  logic [SB-1:0]        in_signal;
  logic                 in_sugar;
  logic                 out_valid;
  logic [XB-1:0]        out_x;
  logic [YB-1:0]        out_y;
  logic [SB-1:0]        cur_signal;
  logic                 cur_sugar;
  logic [7:0][SB-1:0]   surrounding_signals;
  logic                 frame_done;
  logic                 err_sync;

  typedef struct {
    int x;
    int y;
    int sig;
    int sug;
    int surr[8];
  } win_t;

  int   checks   = 0;
  int   failures = 0;
  win_t winQ[$];
  int   gridSig[H][W];
  int   gridSug[H][W];
  bit   expErr  = 1'b0;
  bit   prevRun = 1'b1;
  bit   fd;

  env_window #(.GRID_W(W), .GRID_H(H)) dut (
    .clk                 (clk),
    .RESET_SIM_N         (RESET_SIM_N),
    .run                 (run),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_x                (in_x),
    .in_y                (in_y),
    .in_signal           (in_signal),
    .in_sugar            (in_sugar),
    .out_valid           (out_valid),
    .out_x               (out_x),
    .out_y               (out_y),
    .cur_signal          (cur_signal),
    .cur_sugar           (cur_sugar),
    .surrounding_signals (surrounding_signals),
    .frame_done          (frame_done),
    .err_sync            (err_sync)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int cellSig(input int x, input int y);
    if (x < 0 || x >= W || y < 0 || y >= H) return 0;
    return gridSig[y][x];
  endfunction

  task automatic fillGrid(input bit formula);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (formula) begin
          gridSig[y][x] = x + 4 * y + 1;
          gridSug[y][x] = (x == y) ? 1 : 0;
        end else begin
          gridSig[y][x] = int'($urandom_range(1, 15));
          gridSug[y][x] = int'($urandom_range(0, 1));
        end
      end
    end
  endtask

  // Expected windows in raster order, neighbours looked up by direction offsets.
  task automatic buildWindows();
    int dxs[8];
    int dys[8];
    win_t w;
    dxs = '{0, 1, 1, 1, 0, -1, -1, -1};
    dys = '{-1, -1, 0, 1, 1, 1, 0, -1};
    for (int cy = 0; cy < H; cy++) begin
      for (int cx = 0; cx < W; cx++) begin
        w.x   = cx;
        w.y   = cy;
        w.sig = gridSig[cy][cx];
        w.sug = gridSug[cy][cx];
        for (int d = 0; d < 8; d++) w.surr[d] = cellSig(cx + dxs[d], cy + dys[d]);
        winQ.push_back(w);
      end
    end
  endtask

  task automatic checkOutput(output bit fdOut);
    win_t w;
    fdOut = 1'b0;
    checkEq("errSync", {31'd0, err_sync}, {31'd0, expErr});
    if (!prevRun) checkEq("quietWhileStopped", {31'd0, out_valid}, 32'd0);
    if (out_valid === 1'b1) begin
      checkEq("windowExpected", (winQ.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (winQ.size() > 0) begin
        w = winQ.pop_front();
        checkEq("outX", 32'(out_x), w.x);
        checkEq("outY", 32'(out_y), w.y);
        checkEq("curSignal", 32'(cur_signal), w.sig);
        checkEq("curSugar", {31'd0, cur_sugar}, w.sug);
        for (int d = 0; d < 8; d++) begin
          checkEq($sformatf("surr%0d@(%0d,%0d)", d, w.x, w.y), 32'(surrounding_signals[d]), w.surr[d]);
        end
        checkEq("frameDone", {31'd0, frame_done}, (winQ.size() == 0) ? 32'd1 : 32'd0);
        fdOut = frame_done;
      end
    end else begin
      checkEq("frameDoneIdle", {31'd0, frame_done}, 32'd0);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit v, input int x, input int y,
                               input int sig, input int sug, output bit fdOut);
    @(negedge clk);
    checkOutput(fdOut);
    run       = r;
    in_valid  = v;
    in_x      = XB'(x);
    in_y      = YB'(y);
    in_signal = SB'(sig);
    in_sugar  = sug[0];
    #1;
    prevRun   = r;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkEq({tag, ":outValid"}, {31'd0, out_valid}, 32'd0);
    checkEq({tag, ":frameDone"}, {31'd0, frame_done}, 32'd0);
    checkEq({tag, ":errSync"}, {31'd0, err_sync}, 32'd0);
    checkEq({tag, ":inReady"}, {31'd0, in_ready}, 32'd0);
    checkEq({tag, ":outX"}, 32'(out_x), 32'd0);
    checkEq({tag, ":outY"}, 32'(out_y), 32'd0);
    checkEq({tag, ":curSignal"}, 32'(cur_signal), 32'd0);
    checkEq({tag, ":curSugar"}, {31'd0, cur_sugar}, 32'd0);
    checkEq({tag, ":surr"}, 32'(surrounding_signals), 32'd0);
  endtask

  // One frame: optional in_valid gaps, an optional 5-cycle run=0 pause mid-row,
  // and an optional asynchronous reset once abortAt beats have been consumed.
  task automatic runFrame(input bit formula, input bit gaps, input bit pause,
                          input int abortAt, input string name);
    int fx = 0;
    int fy = 0;
    int beats = 0;
    int padCount = 0;
    int stepCount = 0;
    int pauseLeft = 0;
    int cyc = 0;
    int sig;
    int sug;
    bit started = 1'b0;
    bit paused = 1'b0;
    bit seenDone = 1'b0;
    bit r;
    bit v;
    fillGrid(formula);
    buildWindows();
    while (cyc < 400) begin
      cyc++;
      if (pause && !paused && beats == 6) begin
        pauseLeft = 5;
        paused    = 1'b1;
      end
      r = (pauseLeft == 0);
      if (pauseLeft > 0) pauseLeft--;
      v = (beats < W * H) && (!gaps || $urandom_range(0, 2) != 0);
      sig = (fy < H) ? gridSig[fy][fx] : 0;
      sug = (fy < H) ? gridSug[fy][fx] : 0;
      applyStimulus(r, v, fx, fy, sig, sug, seenDone);
      if (seenDone) break;
      if (r) begin
        if (v && in_ready) begin
          started = 1'b1;
          beats++;
          fx++;
          if (fx == W) begin
            fx = 0;
            fy++;
          end
        end else if (started && !in_ready) begin
          padCount++;
        end
        if (started) stepCount++;
      end
      if (abortAt >= 0 && beats >= abortAt) begin
        @(posedge clk);
        #2;
        RESET_SIM_N = 1'b0;
        #1;
        checkResetOutputs({name, ":midReset"});
        expErr   = 1'b0;
        winQ.delete();
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        RESET_SIM_N = 1'b1;
        return;
      end
    end
    in_valid = 1'b0;
    checkEq({name, ":frameDoneSeen"}, {31'd0, seenDone}, 32'd1);
    checkEq({name, ":padSteps"}, padCount, 32'd8);
    if (!gaps && !pause) checkEq({name, ":totalSteps"}, stepCount, 32'd20);
    checkEq({name, ":windowsLeft"}, winQ.size(), 32'd0);
  endtask

  initial begin
    RESET_SIM_N = 1'b0;
    run         = 1'b1;
    in_valid    = 1'b0;
    in_x        = '0;
    in_y        = '0;
    in_signal   = '0;
    in_sugar    = 1'b0;
    #12;
    checkResetOutputs("powerOnReset");
    @(negedge clk);
    RESET_SIM_N = 1'b1;

    $display("[TB] continuous frame, signal = x+4y+1");
    runFrame(1'b1, 1'b0, 1'b0, -1, "contA");

    $display("[TB] same frame with in_valid gaps and a run pause");
    runFrame(1'b1, 1'b1, 1'b1, -1, "gapsB");

    $display("[TB] mid-frame coordinate mismatch");
    applyStimulus(1'b1, 1'b1, 0, 0, 5, 0, fd);
    applyStimulus(1'b1, 1'b1, 3, 0, 7, 1, fd);
    expErr = 1'b1;
    repeat (4) applyStimulus(1'b1, 1'b0, 0, 0, 0, 0, fd);
    runFrame(1'b0, 1'b0, 1'b0, -1, "afterMismatch");

    $display("[TB] reset during the second row, then a fresh frame");
    runFrame(1'b0, 1'b0, 1'b0, 6, "abortD");
    runFrame(1'b1, 1'b0, 1'b0, -1, "freshE");

    $display("[TB] stray first beat in IDLE");
    applyStimulus(1'b1, 1'b1, 2, 1, 9, 1, fd);
    expErr = 1'b1;
    repeat (3) applyStimulus(1'b1, 1'b0, 0, 0, 0, 0, fd);
    runFrame(1'b0, 1'b1, 1'b0, -1, "afterIdleErr");

    applyStimulus(1'b1, 1'b0, 0, 0, 0, 0, fd);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
